paged_itlb: RTL and testbench
=============================

Name: paged_itlb

Overview:
Page-granular instruction TLB for the fetch stage. It is the parametrised successor of the flat-VA ITLB. It translates the virtual page number (VPN) of the PC and passes the page offset through unchanged. It also adds in-place entry update, a global flush, a faulting-address register and a saturating miss counter for the admin-mode miss handler. The user/admin mode state machine lives inside the block, and its next-state bit is driven down the pipeline.

Parameters:
VA_WIDTH, 32, virtual address width
PA_WIDTH, 20, physical address width
PAGE_BITS, 12, page offset width; VPN = VA_WIDTH-PAGE_BITS bits, PPN = PA_WIDTH-PAGE_BITS bits
NUM_ENTRIES, 16, entry count (any value >= 2, not required to be a power of 2); pointer width = $clog2(NUM_ENTRIES)
MISS_PC, 666, physical fetch address (PA_WIDTH bits) driven on a user-mode miss
CNT_WIDTH, 16, miss counter width

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
pc  in  VA_WIDTH  fetch virtual address
D_admin_change  in  1  from D stage; forces user mode
Wb_tlb_we  in  1  TLB write strobe
WB_tlb_value_va  in  VA_WIDTH  write VA; only the VPN bits [VA_WIDTH-1:PAGE_BITS] are used
WB_tlb_value_pa  in  PA_WIDTH  write PA; only the PPN bits [PA_WIDTH-1:PAGE_BITS] are used
flush  in  1  invalidate all entries
hit  out  1  user-mode translation hit (combinational)
F_pc  out  PA_WIDTH  physical fetch address (combinational)
F_admin  out  1  next-state admin bit (combinational)
miss_va  out  VA_WIDTH  registered pc of the most recent miss event
miss_count  out  CNT_WIDTH  registered, saturating miss-event count

Behaviour:
- Reset (asynchronous): all valid bits = 0, write pointer = 0, mode = USER, miss_va = 0, miss_count = 0.
  - With no entries valid, the first user-mode lookup misses. Therefore, after reset with D_admin_change = 0: hit = 0, F_pc = MISS_PC, F_admin = 1.
- Mode FSM, two states:
  - USER -> ADMIN on a miss event.
  - ADMIN -> USER when D_admin_change = 1.
  - D_admin_change has priority over a miss event: next mode = 0.
  - F_admin = next mode.
- Lookup is combinational and uses the current array contents.
  - Active lookup = (mode == USER) or D_admin_change. When D_admin_change = 1, the same cycle is treated as USER lookup.
  - Hit when a valid entry's VPN equals pc VPN. F_pc = {PPN, pc[PAGE_BITS-1:0]}, hit = 1.
  - Miss: F_pc = MISS_PC, hit = 0, miss event = 1.
  - ADMIN with D_admin_change = 0: F_pc = pc[PA_WIDTH-1:0], hit = 0, no miss event.
- On a miss event at the clock edge:
  - miss_va <= pc.
  - miss_count increments, and holds at all-ones (saturates).
  - These updates happen even when D_admin_change = 1 blocks the mode change.
- Write (Wb_tlb_we = 1, flush = 0), takes effect at the clock edge and is visible to lookup the next cycle:
  - If a valid entry already holds the write VPN: update that entry's PPN in place. The pointer is unchanged.
  - Otherwise: write VPN/PPN at the pointer, set its valid bit, and advance the pointer. The pointer wraps from NUM_ENTRIES-1 to 0 (FIFO replacement, including over valid entries).
  - Because of in-place update, at most one entry ever matches a given VPN.
- flush = 1 at the clock edge:
  - All valid bits = 0 and pointer = 0.
  - A write in the same cycle is discarded.
  - Mode, miss_va and miss_count are unaffected.
  - The lookup in the flush cycle still sees the pre-flush contents.
- Reset asserted mid-operation: immediately returns the block to the reset state, regardless of pending writes or mode.

Test Plan:
1. Reset, pc=0x00001234, D_admin_change=0 -> hit=0, F_pc=666, F_admin=1. Next cycle: mode ADMIN, miss_va=0x00001234, miss_count=1, F_pc=0x01234 (passthrough).
2. In ADMIN, write VA 0x00001000 / PA 0x5A000, then pulse D_admin_change with pc=0x00001ABC -> same cycle hit=1, F_pc=0x5AABC, F_admin=0. Mode is USER afterwards.
3. Write the same VPN 0x00001 with PA 0x3C000 -> pointer stays 1. pc=0x00001004 gives F_pc=0x3C004. No second entry is consumed; verify by filling 15 more distinct VPNs without evicting VPN 0x00001.
4. Write 17 distinct VPNs (0x10..0x20) -> pointer wraps. VPN 0x10 lookup misses (F_pc=666); VPNs 0x11..0x20 hit.
5. Same-cycle flush and Wb_tlb_we for a new VPN -> next cycle, every lookup misses, the written VPN also misses, pointer = 0.
6. Miss with D_admin_change=1 in the same cycle (pc unmapped) -> F_pc=666, F_admin=0. Next cycle: mode USER, miss_count incremented, miss_va = pc. With CNT_WIDTH=2, four misses leave miss_count=3.

Source files
------------

// File: rtl/paged_itlb.sv
// ============================================================================
// Module   : paged_itlb
// Summary  : Page-granular fetch ITLB with in-place update, flush, miss capture
// Revision : 1.0
// ============================================================================
`default_nettype none

module paged_itlb #(
    parameter int                    VA_WIDTH    = 32,
    parameter int                    PA_WIDTH    = 20,
    parameter int                    PAGE_BITS   = 12,
    parameter int                    NUM_ENTRIES = 16,
    parameter logic [PA_WIDTH-1:0]   MISS_PC     = 666,
    parameter int                    CNT_WIDTH   = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [VA_WIDTH-1:0]  pc,
    input  logic                 D_admin_change,
    input  logic                 Wb_tlb_we,
    input  logic [VA_WIDTH-1:0]  WB_tlb_value_va,
    input  logic [PA_WIDTH-1:0]  WB_tlb_value_pa,
    input  logic                 flush,
    output logic                 hit,
    output logic [PA_WIDTH-1:0]  F_pc,
    output logic                 F_admin,
    output logic [VA_WIDTH-1:0]  miss_va,
    output logic [CNT_WIDTH-1:0] miss_count
);

    localparam int VPN_W = VA_WIDTH - PAGE_BITS;
    localparam int PPN_W = PA_WIDTH - PAGE_BITS;
    localparam int PTR_W = $clog2(NUM_ENTRIES);

    localparam logic [0:0] ST_USER  = 1'b0;
    localparam logic [0:0] ST_ADMIN = 1'b1;

    logic [VPN_W-1:0]       r_vpn [NUM_ENTRIES];
    logic [PPN_W-1:0]       r_ppn [NUM_ENTRIES];
    logic [NUM_ENTRIES-1:0] r_valid;
    logic [PTR_W-1:0]       r_ptr;
    logic [0:0]             r_mode;
    logic [0:0]             w_mode_nxt;
    logic [VA_WIDTH-1:0]    r_miss_va;
    logic [CNT_WIDTH-1:0]   r_miss_cnt;

    logic [VPN_W-1:0] w_pc_vpn;
    logic [VPN_W-1:0] w_wr_vpn;
    logic [PPN_W-1:0] w_wr_ppn;
    logic             w_lk_hit;
    logic [PPN_W-1:0] w_lk_ppn;
    logic             w_wr_hit;
    logic [PTR_W-1:0] w_wr_idx;
    logic [PTR_W-1:0] w_ptr_nxt;
    logic             w_active;
    logic             w_miss_evt;
    logic             w_unused;

    assign w_pc_vpn  = pc[VA_WIDTH-1:PAGE_BITS];
    assign w_wr_vpn  = WB_tlb_value_va[VA_WIDTH-1:PAGE_BITS];
    assign w_wr_ppn  = WB_tlb_value_pa[PA_WIDTH-1:PAGE_BITS];
    assign w_unused  = ^{WB_tlb_value_va[PAGE_BITS-1:0], WB_tlb_value_pa[PAGE_BITS-1:0]};
    assign w_ptr_nxt = (r_ptr == PTR_W'(NUM_ENTRIES - 1)) ? '0 : r_ptr + 1'b1;

    // A write VPN is unique in the array, so the write match index is unambiguous.
    always_comb begin
        w_lk_hit = 1'b0;
        w_lk_ppn = '0;
        w_wr_hit = 1'b0;
        w_wr_idx = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (r_valid[i] && (r_vpn[i] == w_pc_vpn)) begin
                w_lk_hit = 1'b1;
                w_lk_ppn = r_ppn[i];
            end
            if (r_valid[i] && (r_vpn[i] == w_wr_vpn)) begin
                w_wr_hit = 1'b1;
                w_wr_idx = PTR_W'(i);
            end
        end
    end

    assign w_active   = (r_mode == ST_USER) || D_admin_change;
    assign w_miss_evt = w_active && !w_lk_hit;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mode <= ST_USER;
        end else begin
            r_mode <= w_mode_nxt;
        end
    end

    always_comb begin
        w_mode_nxt = r_mode;
        if (D_admin_change) begin
            w_mode_nxt = ST_USER;
        end else if (w_miss_evt) begin
            w_mode_nxt = ST_ADMIN;
        end
    end

    always_comb begin
        hit     = w_active && w_lk_hit;
        F_admin = w_mode_nxt[0];
        if (!w_active) begin
            F_pc = pc[PA_WIDTH-1:0];
        end else if (w_lk_hit) begin
            F_pc = {w_lk_ppn, pc[PAGE_BITS-1:0]};
        end else begin
            F_pc = MISS_PC;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= '0;
            r_ptr   <= '0;
        end else if (flush) begin
            r_valid <= '0;
            r_ptr   <= '0;
        end else if (Wb_tlb_we && !w_wr_hit) begin
            r_valid[r_ptr] <= 1'b1;
            r_ptr          <= w_ptr_nxt;
        end
    end

    // Tag/data storage needs no reset: entries are qualified by r_valid.
    always_ff @(posedge clk) begin
        if (Wb_tlb_we && !flush) begin
            if (w_wr_hit) begin
                r_ppn[w_wr_idx] <= w_wr_ppn;
            end else begin
                r_vpn[r_ptr] <= w_wr_vpn;
                r_ppn[r_ptr] <= w_wr_ppn;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_miss_va  <= '0;
            r_miss_cnt <= '0;
        end else if (w_miss_evt) begin
            r_miss_va <= pc;
            if (r_miss_cnt != '1) begin
                r_miss_cnt <= r_miss_cnt + 1'b1;
            end
        end
    end

    assign miss_va    = r_miss_va;
    assign miss_count = r_miss_cnt;

endmodule

`default_nettype wire

// File: tb/tb_paged_itlb.sv
// ============================================================================
// Module   : tb_paged_itlb
// Summary  : Randomized self-checking bench for paged_itlb against a TLB model
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_paged_itlb;

    localparam int              NE   = 6;
    localparam int              CW   = 3;
    localparam logic [19:0]     MPC  = 20'd666;
    localparam int              CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic [31:0]   pc;
    logic          D_admin_change;
    logic          Wb_tlb_we;
    logic [31:0]   WB_tlb_value_va;
    logic [19:0]   WB_tlb_value_pa;
    logic          flush;
    logic          hit;
    logic [19:0]   F_pc;
    logic          F_admin;
    logic [31:0]   miss_va;
    logic [CW-1:0] miss_count;

    paged_itlb #(
        .VA_WIDTH(32), .PA_WIDTH(20), .PAGE_BITS(12),
        .NUM_ENTRIES(NE), .MISS_PC(MPC), .CNT_WIDTH(CW)
    ) u_dut (
        .clk(clk), .reset(reset), .pc(pc), .D_admin_change(D_admin_change),
        .Wb_tlb_we(Wb_tlb_we), .WB_tlb_value_va(WB_tlb_value_va),
        .WB_tlb_value_pa(WB_tlb_value_pa), .flush(flush), .hit(hit),
        .F_pc(F_pc), .F_admin(F_admin), .miss_va(miss_va), .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    // Reference model: FIFO-replaced page table with a user/admin flag.
    bit          m_valid [NE];
    logic [19:0] m_vpn   [NE];
    logic [7:0]  m_ppn   [NE];
    int          m_ptr;
    bit          m_admin;
    logic [31:0] m_miss_va;
    int          m_cnt;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int find(input logic [19:0] vpn);
        for (int i = 0; i < NE; i++)
            if (m_valid[i] && m_vpn[i] == vpn) return i;
        return -1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NE; i++) m_valid[i] = 1'b0;
        m_ptr     = 0;
        m_admin   = 1'b0;
        m_miss_va = '0;
        m_cnt     = 0;
    endtask

    task automatic step(input logic [31:0] a_pc, input bit a_dac, input bit a_we,
                        input logic [31:0] a_va, input logic [19:0] a_pa,
                        input bit a_fl, input bit a_rst);
        bit          active, miss_ev, nxt_admin;
        int          idx, widx;
        logic [19:0] exp_fpc;
        @(negedge clk);
        pc = a_pc; D_admin_change = a_dac; Wb_tlb_we = a_we;
        WB_tlb_value_va = a_va; WB_tlb_value_pa = a_pa; flush = a_fl; reset = a_rst;
        if (a_rst) model_reset();
        #1;
        active  = !m_admin || a_dac;
        idx     = find(a_pc[31:12]);
        miss_ev = active && idx < 0;
        if (!active)      exp_fpc = a_pc[19:0];
        else if (idx >= 0) exp_fpc = {m_ppn[idx], a_pc[11:0]};
        else              exp_fpc = MPC;
        nxt_admin = a_dac ? 1'b0 : (miss_ev ? 1'b1 : m_admin);
        chk("hit", hit, active && idx >= 0);
        chk("F_pc", F_pc, exp_fpc);
        chk("F_admin", F_admin, nxt_admin);
        chk("miss_va", miss_va, m_miss_va);
        chk("miss_count", miss_count, m_cnt);
        @(posedge clk);
        if (!a_rst) begin
            m_admin = nxt_admin;
            if (miss_ev) begin
                m_miss_va = a_pc;
                if (m_cnt < CMAX) m_cnt++;
            end
            if (a_fl) begin
                for (int i = 0; i < NE; i++) m_valid[i] = 1'b0;
                m_ptr = 0;
            end else if (a_we) begin
                widx = find(a_va[31:12]);
                if (widx >= 0) begin
                    m_ppn[widx] = a_pa[19:12];
                end else begin
                    m_vpn[m_ptr]   = a_va[31:12];
                    m_ppn[m_ptr]   = a_pa[19:12];
                    m_valid[m_ptr] = 1'b1;
                    m_ptr          = (m_ptr + 1) % NE;
                end
            end
        end
    endtask

    initial begin
        logic [31:0] r_pc, r_va;
        model_reset();
        step(32'h0, 0, 0, 32'h0, 20'h0, 0, 1);
        step(32'h0, 0, 0, 32'h0, 20'h0, 0, 1);
        // Directed: first miss, admin passthrough, write then return to user.
        step(32'h0000_1234, 0, 0, 32'h0, 20'h0, 0, 0);
        step(32'h0000_1234, 0, 1, 32'h0000_1000, 20'h5A000, 0, 0);
        step(32'h0000_1ABC, 1, 0, 32'h0, 20'h0, 0, 0);
        step(32'h0000_1004, 0, 1, 32'h0000_1000, 20'h3C000, 0, 0);
        step(32'h0000_1004, 0, 0, 32'h0, 20'h0, 0, 0);
        // Fill past capacity so the oldest entry is evicted.
        for (int v = 16; v < 16 + NE + 1; v++)
            step(32'h0000_1004, 0, 1, {12'h0, v[7:0], 12'h0}, {v[7:0], 12'h0}, 0, 0);
        for (int v = 16; v < 16 + NE + 1; v++)
            step({12'h0, v[7:0], 12'h0A4}, 1, 0, 32'h0, 20'h0, 0, 0);
        // Flush colliding with a write, then look the written page up.
        step(32'h0001_1000, 1, 1, 32'h0000_2000, 20'h77000, 1, 0);
        step(32'h0000_2010, 1, 0, 32'h0, 20'h0, 0, 0);
        step(32'h0001_1000, 1, 0, 32'h0, 20'h0, 0, 0);
        for (int n = 0; n < 3000; n++) begin
            r_pc = {12'h0, 8'($urandom_range(0, 11)), 12'($urandom)};
            if ($urandom_range(0, 15) == 0) r_pc = $urandom;
            r_va = {12'h0, 8'($urandom_range(0, 11)), 12'($urandom)};
            step(r_pc, $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0, r_va,
                 20'($urandom), $urandom_range(0, 15) == 0, $urandom_range(0, 63) == 0);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
